// File: rtl/user_ram_pkg.sv
// Shared types and helpers for the user RAM controller and its storage core.
package user_ram_pkg;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_t;

  localparam int RDW_OLD = 0;
  localparam int RDW_NEW = 1;

  function automatic int be_width(input int data_w);
    return data_w / 8;
  endfunction

endpackage

// File: rtl/user_ram_ctrl_if.sv
// Core-side memory bus: requests from master, read data and status back from slave.
interface user_ram_ctrl_if #(
  parameter int DATA_W   = 32,
  parameter int ADDR_BIT = 8
) ();

  localparam int BE_W = user_ram_pkg::be_width(DATA_W);

  logic                clr;
  logic                wr_en;
  logic                rd_en;
  logic [ADDR_BIT-1:0] addr;
  logic [BE_W-1:0]     be;
  logic [DATA_W-1:0]   di;
  logic [DATA_W-1:0]   dout;
  logic                rd_valid;
  logic                busy;
  logic                err;

  modport master (
    output clr, wr_en, rd_en, addr, be, di,
    input  dout, rd_valid, busy, err
  );

  modport slave (
    input  clr, wr_en, rd_en, addr, be, di,
    output dout, rd_valid, busy, err
  );

endinterface

// File: rtl/user_ram_core.sv
// Bare single-port storage: per-byte write enables, read-before-write registered output.
module user_ram_core #(
  parameter  int DATA_W   = 32,
  parameter  int ADDR_BIT = 8,
  localparam int BE_W     = DATA_W / 8
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                we,
  input  logic                re,
  input  logic [BE_W-1:0]     be,
  input  logic [ADDR_BIT-1:0] addr,
  input  logic [DATA_W-1:0]   wdata,
  output logic [DATA_W-1:0]   rdata
);

  logic [DATA_W-1:0] mem [2**ADDR_BIT];

  always_ff @(posedge clk_i) begin
    if (we) begin
      for (int k = 0; k < BE_W; k++) begin
        if (be[k]) mem[addr][8*k +: 8] <= wdata[8*k +: 8];
      end
    end
  end

  // Only the output register is reset; the array relies on the clear engine.
  always_ff @(posedge clk_i) begin
    if (rst_i)   rdata <= '0;
    else if (re) rdata <= mem[addr];
  end

endmodule

// File: rtl/user_ram_ctrl.sv
// RAM controller: zero-clear FSM, request gating, read-during-write merge, status pulses.
module user_ram_ctrl
  import user_ram_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int ADDR_BIT = 8,
  parameter int RDW_MODE = RDW_OLD
) (
  input  logic           clk_i,
  input  logic           rst_i,
  user_ram_ctrl_if.slave bus
);

  localparam int BE_W = be_width(DATA_W);

  state_t              state;
  logic [ADDR_BIT-1:0] cnt;
  logic                idle, req, accept;
  logic                mem_we, mem_re;
  logic [BE_W-1:0]     mem_be;
  logic [ADDR_BIT-1:0] mem_addr;
  logic [DATA_W-1:0]   mem_wdata, mem_rdata, merged;
  logic [BE_W-1:0]     be_q;
  logic [DATA_W-1:0]   di_q;
  logic                rd_valid_q, err_q;

  assign idle   = (state == ST_IDLE);
  assign req    = bus.wr_en | bus.rd_en;
  assign accept = idle & ~bus.clr;

  always_comb begin
    mem_we    = 1'b0;
    mem_re    = 1'b0;
    mem_be    = '0;
    mem_addr  = bus.addr;
    mem_wdata = bus.di;
    if (!idle) begin
      mem_we    = 1'b1;
      mem_be    = '1;
      mem_addr  = cnt;
      mem_wdata = '0;
    end else if (!bus.clr) begin
      mem_we = bus.wr_en;
      mem_re = bus.rd_en;
      mem_be = bus.be;
    end
    if (rst_i) begin
      mem_we = 1'b0;
      mem_re = 1'b0;
    end
  end

  user_ram_core #(
    .DATA_W   (DATA_W),
    .ADDR_BIT (ADDR_BIT)
  ) u_core (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .we    (mem_we),
    .re    (mem_re),
    .be    (mem_be),
    .addr  (mem_addr),
    .wdata (mem_wdata),
    .rdata (mem_rdata)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state      <= ST_CLEAR;
      cnt        <= '0;
      rd_valid_q <= 1'b0;
      err_q      <= 1'b0;
      be_q       <= '0;
      di_q       <= '0;
    end else begin
      rd_valid_q <= accept & bus.rd_en;
      err_q      <= req & ~accept;
      // Core always returns the pre-write word; new bytes are overlaid at the output.
      if (accept && bus.rd_en) begin
        be_q <= (RDW_MODE == RDW_NEW && bus.wr_en) ? bus.be : '0;
        di_q <= bus.di;
      end
      case (state)
        ST_CLEAR: begin
          cnt <= cnt + 1'b1;
          if (cnt == '1) state <= ST_IDLE;
        end
        ST_IDLE: begin
          if (bus.clr) begin
            state <= ST_CLEAR;
            cnt   <= '0;
          end
        end
        default: state <= ST_CLEAR;
      endcase
    end
  end

  always_comb begin
    merged = mem_rdata;
    for (int k = 0; k < BE_W; k++) begin
      if (be_q[k]) merged[8*k +: 8] = di_q[8*k +: 8];
    end
  end

  assign bus.dout     = merged;
  assign bus.rd_valid = rd_valid_q;
  assign bus.err      = err_q;
  assign bus.busy     = ~idle;

endmodule

// File: tb/tb_user_ram_ctrl.sv
// Directed bench for user_ram_ctrl: two instances (old-data and new-data read-during-write) share stimulus.
module tb_user_ram_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        clr, wr_en, rd_en;
  logic [3:0]  addr;
  logic [3:0]  be;
  logic [31:0] di;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  user_ram_ctrl_if #(.DATA_W(32), .ADDR_BIT(4)) bus0 ();
  user_ram_ctrl_if #(.DATA_W(32), .ADDR_BIT(4)) bus1 ();

  assign bus0.clr = clr;   assign bus1.clr = clr;
  assign bus0.wr_en = wr_en; assign bus1.wr_en = wr_en;
  assign bus0.rd_en = rd_en; assign bus1.rd_en = rd_en;
  assign bus0.addr = addr; assign bus1.addr = addr;
  assign bus0.be = be;     assign bus1.be = be;
  assign bus0.di = di;     assign bus1.di = di;

  user_ram_ctrl #(.DATA_W(32), .ADDR_BIT(4), .RDW_MODE(0)) dut0 (.clk_i(clk), .rst_i(rst), .bus(bus0));
  user_ram_ctrl #(.DATA_W(32), .ADDR_BIT(4), .RDW_MODE(1)) dut1 (.clk_i(clk), .rst_i(rst), .bus(bus1));

  task automatic drive(input logic w, input logic r, input logic c,
                       input logic [3:0] a, input logic [3:0] b, input logic [31:0] d);
    wr_en = w; rd_en = r; clr = c; addr = a; be = b; di = d;
    @(negedge clk);
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 32'h0);
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (bus0.busy && n < 40) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    int n;
    rst = 1'b1;
    @(negedge clk);
    checks++; if (bus0.dout !== 32'h0 || bus1.dout !== 32'h0) begin errors++; $display("FAIL reset_dout: got %h/%h expected 0", bus0.dout, bus1.dout); end
    checks++; if (bus0.rd_valid !== 1'b0 || bus0.err !== 1'b0) begin errors++; $display("FAIL reset_pulses: got valid=%b err=%b expected 0/0", bus0.rd_valid, bus0.err); end
    checks++; if (bus0.busy !== 1'b1) begin errors++; $display("FAIL reset_busy: got %b expected 1", bus0.busy); end
    rst = 1'b0;
    wait_idle(n);
    checks++; if (n !== 16) begin errors++; $display("FAIL reset_clear_len: got %0d busy cycles expected 16", n); end
    for (int i = 0; i < 16; i++) begin
      drive(1'b0, 1'b1, 1'b0, 4'(i), 4'h0, 32'h0);
      checks++; if (bus0.rd_valid !== 1'b1 || bus0.dout !== 32'h0) begin errors++; $display("FAIL reset_read[%0d]: got valid=%b data=%h expected 1/00000000", i, bus0.rd_valid, bus0.dout); end
    end
    idle();
    checks++; if (bus0.rd_valid !== 1'b0) begin errors++; $display("FAIL reset_valid_drop: got %b expected 0", bus0.rd_valid); end
  endtask

  task automatic test_byte_strobe();
    drive(1'b1, 1'b0, 1'b0, 4'd3, 4'hF, 32'hAABBCCDD);
    drive(1'b1, 1'b0, 1'b0, 4'd3, 4'b0101, 32'h11223344);
    drive(1'b0, 1'b1, 1'b0, 4'd3, 4'h0, 32'h0);
    checks++; if (bus0.dout !== 32'hAA22CC44 || bus1.dout !== 32'hAA22CC44) begin errors++; $display("FAIL byte_strobe: got %h/%h expected aa22cc44", bus0.dout, bus1.dout); end
    drive(1'b1, 1'b0, 1'b0, 4'd3, 4'h0, 32'hFFFFFFFF);
    drive(1'b0, 1'b1, 1'b0, 4'd3, 4'h0, 32'h0);
    checks++; if (bus0.dout !== 32'hAA22CC44) begin errors++; $display("FAIL be_zero_noop: got %h expected aa22cc44", bus0.dout); end
    idle();
    idle();
    checks++; if (bus0.dout !== 32'hAA22CC44 || bus0.rd_valid !== 1'b0) begin errors++; $display("FAIL dout_hold: got %h valid=%b expected aa22cc44/0", bus0.dout, bus0.rd_valid); end
  endtask

  task automatic test_rdw();
    drive(1'b1, 1'b1, 1'b0, 4'd5, 4'hF, 32'hDEADBEEF);
    checks++; if (bus0.dout !== 32'h0) begin errors++; $display("FAIL rdw_old: got %h expected 00000000", bus0.dout); end
    checks++; if (bus1.dout !== 32'hDEADBEEF) begin errors++; $display("FAIL rdw_new: got %h expected deadbeef", bus1.dout); end
    checks++; if (bus0.rd_valid !== 1'b1 || bus1.rd_valid !== 1'b1) begin errors++; $display("FAIL rdw_valid: got %b/%b expected 1/1", bus0.rd_valid, bus1.rd_valid); end
    drive(1'b0, 1'b1, 1'b0, 4'd5, 4'h0, 32'h0);
    checks++; if (bus0.dout !== 32'hDEADBEEF || bus1.dout !== 32'hDEADBEEF) begin errors++; $display("FAIL rdw_followup: got %h/%h expected deadbeef", bus0.dout, bus1.dout); end
    drive(1'b1, 1'b1, 1'b0, 4'd5, 4'b0011, 32'h12345678);
    checks++; if (bus0.dout !== 32'hDEADBEEF) begin errors++; $display("FAIL rdw_old_partial: got %h expected deadbeef", bus0.dout); end
    checks++; if (bus1.dout !== 32'hDEAD5678) begin errors++; $display("FAIL rdw_new_partial: got %h expected dead5678", bus1.dout); end
    idle();
  endtask

  task automatic test_busy_drop();
    int n;
    drive(1'b1, 1'b0, 1'b0, 4'd7, 4'hF, 32'h00000055);
    drive(1'b0, 1'b0, 1'b1, 4'd0, 4'h0, 32'h0);
    checks++; if (bus0.busy !== 1'b1 || bus0.err !== 1'b0) begin errors++; $display("FAIL clr_start: got busy=%b err=%b expected 1/0", bus0.busy, bus0.err); end
    drive(1'b1, 1'b0, 1'b0, 4'd2, 4'hF, 32'h12345678);
    checks++; if (bus0.err !== 1'b1) begin errors++; $display("FAIL busy_wr_err: got %b expected 1", bus0.err); end
    drive(1'b0, 1'b1, 1'b0, 4'd2, 4'h0, 32'h0);
    checks++; if (bus0.err !== 1'b1 || bus0.rd_valid !== 1'b0) begin errors++; $display("FAIL busy_rd_drop: got err=%b valid=%b expected 1/0", bus0.err, bus0.rd_valid); end
    drive(1'b0, 1'b0, 1'b1, 4'd0, 4'h0, 32'h0);
    checks++; if (bus0.err !== 1'b0) begin errors++; $display("FAIL clr_in_clear_err: got %b expected 0", bus0.err); end
    idle();
    wait_idle(n);
    checks++; if (bus0.busy !== 1'b0) begin errors++; $display("FAIL busy_timeout: got busy=%b expected 0", bus0.busy); end
    drive(1'b0, 1'b1, 1'b0, 4'd2, 4'h0, 32'h0);
    checks++; if (bus0.dout !== 32'h0 || bus0.rd_valid !== 1'b1) begin errors++; $display("FAIL busy_drop_read: got %h valid=%b expected 00000000/1", bus0.dout, bus0.rd_valid); end
    drive(1'b1, 1'b0, 1'b1, 4'd7, 4'hF, 32'h00000099);
    checks++; if (bus0.err !== 1'b1 || bus0.busy !== 1'b1) begin errors++; $display("FAIL clr_wins: got err=%b busy=%b expected 1/1", bus0.err, bus0.busy); end
    idle();
    wait_idle(n);
    drive(1'b0, 1'b1, 1'b0, 4'd7, 4'h0, 32'h0);
    checks++; if (bus0.dout !== 32'h0) begin errors++; $display("FAIL clr_zeroes: got %h expected 00000000", bus0.dout); end
    idle();
  endtask

  task automatic test_reset_midclear();
    int n;
    drive(1'b1, 1'b0, 1'b0, 4'd4, 4'hF, 32'hCAFEF00D);
    drive(1'b0, 1'b1, 1'b0, 4'd4, 4'h0, 32'h0);
    checks++; if (bus0.dout !== 32'hCAFEF00D) begin errors++; $display("FAIL pre_mid_read: got %h expected cafef00d", bus0.dout); end
    drive(1'b0, 1'b0, 1'b1, 4'd0, 4'h0, 32'h0);
    for (int i = 0; i < 5; i++) idle();
    rst = 1'b1;
    @(negedge clk);
    checks++; if (bus0.dout !== 32'h0 || bus1.dout !== 32'h0 || bus0.rd_valid !== 1'b0) begin errors++; $display("FAIL mid_reset_out: got %h/%h valid=%b expected 0/0/0", bus0.dout, bus1.dout, bus0.rd_valid); end
    rst = 1'b0;
    wait_idle(n);
    checks++; if (n !== 16) begin errors++; $display("FAIL mid_reset_len: got %0d busy cycles expected 16", n); end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 8; i++) drive(1'b1, 1'b0, 1'b0, 4'(i), 4'hF, 32'(i * 3));
    for (int i = 0; i < 8; i++) begin
      drive(1'b0, 1'b1, 1'b0, 4'(i), 4'h0, 32'h0);
      checks++; if (bus0.rd_valid !== 1'b1 || bus0.dout !== 32'(i * 3)) begin errors++; $display("FAIL stream[%0d]: got valid=%b data=%h expected 1/%h", i, bus0.rd_valid, bus0.dout, 32'(i * 3)); end
    end
    idle();
    checks++; if (bus0.rd_valid !== 1'b0) begin errors++; $display("FAIL stream_end: got valid=%b expected 0", bus0.rd_valid); end
  endtask

  initial begin
    rst = 1'b1; clr = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
    addr = 4'h0; be = 4'h0; di = 32'h0;
    @(negedge clk);
    test_reset();
    test_byte_strobe();
    test_rdw();
    test_busy_drop();
    test_reset_midclear();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
